// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction-fetch front end for the single-cycle core. It keeps a sequential
// fetch PC, fetches over a request/acknowledge memory port of variable latency
// with at most one request outstanding, and buffers fetched {pc, inst} pairs in
// a DEPTH-entry FIFO that the core drains with a valid/ready handshake. A core
// redirect flushes the FIFO and any in-flight fetch.
//
// Parameters
//   DEPTH     FIFO entries; power of two, 2..8
//   RESET_PC  fetch PC after reset; bit 0 must be 0
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   redirect_valid    core taken branch/jump this cycle
//   redirect_pc       new fetch address (bit 0 forced to 0)
//   inst_valid        FIFO head holds an instruction
//   inst, inst_pc     FIFO head word and the address it was fetched from
//   inst_ready        core consumes the head when inst_valid & inst_ready
//   mem_req           fetch request (registered)
//   mem_addr          fetch address (registered, stable while mem_req=1)
//   mem_ack           one-cycle pulse, mem_rdata valid
//   mem_rdata         instruction word for mem_addr
// -----------------------------------------------------------------------------
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } fetch_entry_t;

  // DRAIN: a redirect landed while a request was still in flight; the request
  // cannot be withdrawn, so we wait out its ack and throw the data away.
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  fifo_q [DEPTH];
  fetch_entry_t  head;

  logic          push, pop, has_space;
  logic [15:0]   redirect_tgt;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign redirect_tgt = redirect_pc & 16'hFFFE;

  // Redirect wins over both sides: the head is flushed even if the core is
  // ready, and an ack arriving with the redirect is for a stale address.
  assign pop  = inst_valid & inst_ready & ~redirect_valid;
  assign push = (state_q == WAIT) & mem_ack & ~redirect_valid;

  always_comb begin
    count_d = count_q;
    if (redirect_valid) count_d = '0;
    else                count_d = count_q + CW'(push) - CW'(pop);
  end

  // Issue decision looks at post-pop occupancy, so a pop frees room for a
  // request on the same edge.
  assign has_space = (count_d < CW'(DEPTH));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_tgt;
    else if (push)      fetch_pc_d = fetch_pc_q + 16'd2;
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (has_space) begin
          state_d    = WAIT;
          mem_addr_d = fetch_pc_d;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          if (mem_ack) begin
            // Ack retires the request; re-issue straight at the target.
            state_d    = WAIT;
            mem_addr_d = fetch_pc_d;
          end else begin
            state_d    = DRAIN;
          end
        end else if (mem_ack) begin
          if (has_space) begin
            state_d    = WAIT;
            mem_addr_d = fetch_pc_d;
          end else begin
            state_d    = IDLE;
          end
        end
      end
      DRAIN: begin
        // fetch_pc_d already holds the newest redirect target, including one
        // that arrives in the same cycle as the discarded ack.
        if (mem_ack) begin
          state_d    = WAIT;
          mem_addr_d = fetch_pc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage, one register per slot. DEPTH is a power of two so the
  // pointers wrap naturally.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        fifo_q[i] <= '0;
      else if (push && (wr_ptr_q == PW'(i)))
        fifo_q[i] <= '{pc: fetch_pc_q, inst: mem_rdata};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. An empty FIFO still shows whatever sits in the head slot.
  // ---------------------------------------------------------------------------
  assign head       = fifo_q[rd_ptr_q];
  assign inst_valid = (count_q != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign mem_req    = (state_q != IDLE);
  assign mem_addr   = mem_addr_q;

endmodule
